// File: rtl/cnt_ctrl_pkg.sv
// cnt_ctrl shared definitions.
// State encoding and default sizing.
package cnt_ctrl_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cnt_ctrl_if.sv
// cnt_ctrl control/status bundle.
// master drives commands, slave is the sequencer.
interface cnt_ctrl_if
  import cnt_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             Start;
  logic             Stop;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Limit;
  logic             Up;
  logic             Auto;
  logic [WIDTH-1:0] Q;
  logic             Busy;
  logic             Done;
  logic             Wrap;

  modport master (
    output Start, Stop, Load,
    output D, Limit, Up, Auto,
    input  Q, Busy, Done, Wrap
  );

  modport slave (
    input  Start, Stop, Load,
    input  D, Limit, Up, Auto,
    output Q, Busy, Done, Wrap
  );

endinterface

// File: rtl/cnt_ctrl_dp.sv
// cnt_ctrl count register.
// Load beats enable; enable steps by up_i.
module cnt_ctrl_dp #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // next count: parallel load, step, or hold
  always_comb begin
    q_d = q_q;
    if (ld_i) begin
      q_d = ld_val_i;
    end else if (en_i) begin
      q_d = up_i ? q_q + 1'b1 : q_q - 1'b1;
    end
  end

  // count register, cleared on reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/cnt_ctrl.sv
// cnt_ctrl sequencer: IDLE/RUN/PAUSE/DONE.
// Drives the count register and status pulses.
module cnt_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic       Clock,
  input  logic       Resetn,
  cnt_ctrl_if.slave  bus
);

  state_e           state_q;
  state_e           state_d;
  logic             done_q;
  logic             done_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic             en;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] s_val;
  logic [WIDTH-1:0] t_val;
  logic             at_t;

  // direction picks start value and terminal
  always_comb begin
    s_val = bus.Up ? '0 : bus.Limit;
    t_val = bus.Up ? bus.Limit : '0;
    at_t  = (q == t_val);
  end

  // next state, register controls, pulses
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    ld_val  = bus.D;
    en      = 1'b0;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    if (bus.Load) begin
      ld      = 1'b1;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.Start) begin
            ld      = 1'b1;
            ld_val  = s_val;
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.Stop) begin
            state_d = PAUSE;
          end else if (at_t && bus.Auto) begin
            ld     = 1'b1;
            ld_val = s_val;
            wrap_d = 1'b1;
          end else if (at_t) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            en = 1'b1;
          end
        end
        PAUSE: begin
          if (bus.Stop) begin
            state_d = IDLE;
          end else if (bus.Start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (bus.Stop) begin
            state_d = IDLE;
          end else if (bus.Start) begin
            ld      = 1'b1;
            ld_val  = s_val;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state and pulse registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  cnt_ctrl_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk_i    (Clock),
    .rst_n_i  (Resetn),
    .ld_i     (ld),
    .ld_val_i (ld_val),
    .en_i     (en),
    .up_i     (bus.Up),
    .q_o      (q)
  );

  assign bus.Q    = q;
  assign bus.Busy = (state_q == RUN);
  assign bus.Done = done_q;
  assign bus.Wrap = wrap_q;

endmodule

// File: tb/tb_cnt_ctrl.sv
// cnt_ctrl bench: directed stimulus,
// behavioural model plus literal checks.
module tb_cnt_ctrl;

  logic Clock  = 1'b0;
  logic Resetn = 1'b1;

  cnt_ctrl_if #(.WIDTH(4)) bus ();

  cnt_ctrl #(.WIDTH(4)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus.slave)
  );

  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // model: mode 0 stopped, 1 counting, 2 paused, 3 finished
  int m_mode = 0;
  int m_q    = 0;
  int m_done = 0;
  int m_wrap = 0;

  always @(posedge Clock or negedge Resetn) begin
    int s, t;
    if (!Resetn) begin
      m_mode = 0; m_q = 0; m_done = 0; m_wrap = 0;
    end else begin
      s = bus.Up ? 0 : int'(bus.Limit);
      t = bus.Up ? int'(bus.Limit) : 0;
      m_done = 0;
      m_wrap = 0;
      if (bus.Load) begin
        m_q = int'(bus.D);
        m_mode = 0;
      end else if (m_mode == 0) begin
        if (bus.Start) begin m_q = s; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (bus.Stop) m_mode = 2;
        else if (m_q == t) begin
          if (bus.Auto) begin m_q = s; m_wrap = 1; end
          else begin m_done = 1; m_mode = 3; end
        end else begin
          m_q = (m_q + (bus.Up ? 1 : 15)) % 16;
        end
      end else if (m_mode == 2) begin
        if (bus.Stop) m_mode = 0;
        else if (bus.Start) m_mode = 1;
      end else begin
        if (bus.Stop) m_mode = 0;
        else if (bus.Start) begin m_q = s; m_mode = 1; end
      end
    end
  end

  // every-cycle compare against the model
  always @(negedge Clock) begin
    check("q",    int'(bus.Q),    m_q);
    check("busy", int'(bus.Busy), int'(m_mode == 1));
    check("done", int'(bus.Done), m_done);
    check("wrap", int'(bus.Wrap), m_wrap);
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge Clock);
  endtask

  task automatic idle_in();
    bus.Start = 0; bus.Stop = 0; bus.Load = 0;
  endtask

  int exp_q [6] = '{1, 2, 3, 4, 5, 5};
  int exp_d [6] = '{0, 0, 0, 0, 0, 1};
  int wraps;
  int wrap_bad;
  int dones;

  initial begin
    idle_in();
    bus.D = 0; bus.Limit = 0; bus.Up = 1; bus.Auto = 0;
    #1 Resetn = 0;
    step(2);
    check("rst_q", int'(bus.Q), 0);
    check("rst_busy", int'(bus.Busy), 0);
    Resetn = 1;
    step(1);

    // one-shot up to 5
    bus.Limit = 5; bus.Up = 1; bus.Auto = 0; bus.Start = 1;
    step(1);
    bus.Start = 0;
    check("a_start_q", int'(bus.Q), 0);
    check("a_start_busy", int'(bus.Busy), 1);
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("a_q", int'(bus.Q), exp_q[i]);
      check("a_done", int'(bus.Done), exp_d[i]);
    end
    check("a_busy_end", int'(bus.Busy), 0);
    step(1);
    check("a_done_clr", int'(bus.Done), 0);

    // auto-reload, limit 3
    bus.Limit = 3; bus.Auto = 1; bus.Start = 1;
    step(1);
    bus.Start = 0;
    wraps = 0; wrap_bad = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (bus.Wrap) begin
        wraps++;
        if (bus.Q != 0) wrap_bad++;
      end
    end
    check("b_wraps", wraps, 3);
    check("b_wrap_q0", wrap_bad, 0);
    check("b_q", int'(bus.Q), 0);
    bus.Stop = 1; step(2); bus.Stop = 0;
    check("b_idle", int'(bus.Busy), 0);

    // down from 9 with pause at 6
    bus.Limit = 9; bus.Up = 0; bus.Auto = 0; bus.Start = 1;
    step(1);
    bus.Start = 0;
    check("c_start_q", int'(bus.Q), 9);
    step(3);
    bus.Stop = 1; step(1); bus.Stop = 0;
    step(3);
    check("c_pause_q", int'(bus.Q), 6);
    check("c_pause_busy", int'(bus.Busy), 0);
    bus.Start = 1; step(1); bus.Start = 0;
    check("c_resume_q", int'(bus.Q), 6);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (bus.Done) dones++;
    end
    check("c_dones", dones, 1);
    check("c_end_q", int'(bus.Q), 0);

    // load+stop+start in RUN
    bus.Up = 1; bus.Limit = 15; bus.Start = 1;
    step(3);
    bus.Load = 1; bus.Stop = 1; bus.D = 4'hA;
    step(1);
    idle_in();
    check("d_q", int'(bus.Q), 10);
    check("d_busy", int'(bus.Busy), 0);
    step(2);
    check("d_hold", int'(bus.Q), 10);

    // load 7 then start reloads to 0
    bus.Limit = 2; bus.D = 7; bus.Load = 1;
    step(1); bus.Load = 0;
    check("e_load", int'(bus.Q), 7);
    bus.Start = 1; step(1); bus.Start = 0;
    check("e_start", int'(bus.Q), 0);
    step(3);
    check("e_q", int'(bus.Q), 2);
    check("e_done", int'(bus.Done), 1);
    bus.Start = 1;
    step(2);
    check("e_noreset", int'(bus.Q), 1);
    step(2);
    bus.Start = 0;
    check("e_done2", int'(bus.Done), 1);
    step(1);

    // limit below Q while counting up
    bus.Limit = 15; bus.Start = 1; step(1); bus.Start = 0;
    step(5);
    check("f_q5", int'(bus.Q), 5);
    bus.Limit = 2;
    step(13);
    check("f_wrapq", int'(bus.Q), 2);
    step(1);
    check("f_done", int'(bus.Done), 1);

    // async reset mid-run at Q=5
    bus.Limit = 9; bus.Start = 1; step(1); bus.Start = 0;
    step(5);
    check("g_q5", int'(bus.Q), 5);
    #2 Resetn = 0;
    #1;
    check("g_rst_q", int'(bus.Q), 0);
    check("g_rst_busy", int'(bus.Busy), 0);
    check("g_rst_done", int'(bus.Done), 0);
    check("g_rst_wrap", int'(bus.Wrap), 0);
    step(1);
    Resetn = 1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
